// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter over 4 byte requesters feeding an LSB-first serial shifter (sclk/sdata).
// Capture takes 1 cycle; a frame is 16*DIV shift cycles plus a GAP_BITS*2*DIV idle gap; requests wait while busy.
module serial_tx_arbiter #(
  parameter int DIV      = 1024,
  parameter int GAP_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        sclk,
  output logic        sdata
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;
  logic [7:0]    bit_q, bit_d;
  logic [6:0]    shreg_q, shreg_d;
  logic [1:0]    rr_q, rr_d;
  logic [3:0]    ack_q, ack_d;
  logic [1:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic          sdata_q, sdata_d;

  logic          found;
  logic [1:0]    win;
  logic          half_end;

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign sdata    = sdata_q;

  assign half_end = (cnt_q == CW'(DIV - 1));

  // First set request bit scanning upward from rr_q, wrapping 3->0.
  always_comb begin : arb
    logic [1:0] idx;
    found = 1'b0;
    win   = rr_q;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rr_d    = rr_q;
    ack_d   = '0;
    grant_d = grant_q;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SHIFT;
          shreg_d = req_data[{win, 3'b000} + 5'd1 +: 7];
          sdata_d = req_data[{win, 3'b000}];
          grant_d = win;
          ack_d   = 4'b0001 << win;
          rr_d    = win + 2'd1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (!half_end) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
            sclk_d = 1'b1;
          end else begin
            half_d = 1'b0;
            sclk_d = 1'b0;
            if (bit_q == 8'd7) begin
              state_d = GAP;
              bit_d   = '0;
              sdata_d = 1'b0;
            end else begin
              // Next bit is presented together with the falling sclk edge.
              bit_d   = bit_q + 8'd1;
              sdata_d = shreg_q[0];
              shreg_d = {1'b0, shreg_q[6:1]};
            end
          end
        end
      end
      GAP: begin
        if (!half_end) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d  = '0;
          half_d = ~half_q;
          if (half_q) begin
            if (bit_q == 8'(GAP_BITS - 1)) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 8'd1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      shreg_q <= '0;
      rr_q    <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: a frame-timeline model checked every cycle plus directed literal checks.
module tb_serial_tx_arbiter;

  localparam int DIV       = 2;
  localparam int GAP_BITS  = 1;
  localparam int SHIFT_CYC = 16 * DIV;
  localparam int FRAME     = SHIFT_CYC + 2 * DIV * GAP_BITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        sclk;
  logic        sdata;

  always #5 clk = ~clk;

  serial_tx_arbiter #(.DIV(DIV), .GAP_BITS(GAP_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .sclk     (sclk),
    .sdata    (sdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a timeline indexed by cycles since the capture edge.
  bit         m_idle = 1'b1;
  int         m_t = 0;
  int         m_ptr = 0;
  int         m_grant = 0;
  int         m_win = 0;
  logic [7:0] m_byte = '0;
  int         w, idx;

  always @(posedge clk) begin
    if (rst) begin
      m_idle  = 1'b1;
      m_t     = 0;
      m_ptr   = 0;
      m_grant = 0;
    end else if (!m_idle) begin
      m_t++;
      if (m_t == FRAME) m_idle = 1'b1;
    end else if (req != 0) begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (w < 0 && req[idx]) w = idx;
      end
      m_win   = w;
      m_grant = w;
      m_byte  = req_data[8*w +: 8];
      m_ptr   = (w + 1) % 4;
      m_t     = 0;
      m_idle  = 1'b0;
    end
  end

  bit cmp_en = 1'b0;
  int e_busy, e_sclk, e_sdata, e_ack;
  int cyc = 0;
  int viol = 0;
  int ack_cnt = 0;
  int busy_run = 0;
  int last_busy_run = 0;
  int prev_sclk = 0;
  int grants[$];
  int rise_bits[$];
  int rise_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (cmp_en) begin
      if (m_idle) begin
        e_busy = 0; e_sclk = 0; e_sdata = 0; e_ack = 0;
      end else begin
        e_busy = 1;
        e_ack  = (m_t == 0) ? (1 << m_win) : 0;
        if (m_t < SHIFT_CYC) begin
          e_sclk  = ((m_t % (2*DIV)) >= DIV) ? 1 : 0;
          e_sdata = int'(m_byte[m_t / (2*DIV)]);
        end else begin
          e_sclk = 0; e_sdata = 0;
        end
      end
      chk("cmp_busy", int'(busy), e_busy);
      chk("cmp_sclk", int'(sclk), e_sclk);
      chk("cmp_sdata", int'(sdata), e_sdata);
      chk("cmp_ack", int'(ack), e_ack);
      chk("cmp_grant_id", int'(grant_id), m_grant);
      chk("cmp_ack_onehot0", int'($onehot0(ack)), 1);
    end
    if (busy || sclk || sdata || ack != 0) viol++;
    if (ack != 0) begin
      ack_cnt++;
      for (int k = 0; k < 4; k++) if (ack[k]) grants.push_back(k);
    end
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy_run = busy_run;
      busy_run = 0;
    end
    if (sclk && prev_sclk == 0) begin
      rise_bits.push_back(int'(sdata));
      rise_cyc.push_back(cyc);
    end
    prev_sclk = int'(sclk);
  end

  task automatic wait_ack(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (ack == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ack_in_time"}, int'(ack != 0), 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_in_time"}, int'(!busy), 1);
  endtask

  task automatic wait_grants(input int num, input int budget);
    int n;
    n = 0;
    while (grants.size() < num && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("grants_in_time", int'(grants.size() >= num), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int a0, v0;
    int exp_seq[8];
    int exp_rr[5];
    exp_seq = '{1, 0, 1, 0, 0, 1, 0, 1};
    exp_rr  = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_sdata", int'(sdata), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    rst = 1'b0;

    // Quiet idle for 100 cycles
    @(posedge clk);
    v0 = viol;
    repeat (100) @(negedge clk);
    @(posedge clk);
    chk("idle_quiet_violations", viol - v0, 0);

    // Single frame of 8'hA5; data changed right after capture
    rise_bits.delete();
    rise_cyc.delete();
    a0 = ack_cnt;
    @(negedge clk);
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    wait_ack("f1", 50);
    chk("f1_ack_value", int'(ack), 1);
    req = 4'b0000;
    @(negedge clk);
    req_data[7:0] = 8'h00;
    wait_idle("f1", 200);
    @(posedge clk);
    chk("f1_sclk_rises", rise_bits.size(), 8);
    for (int i = 0; i < 8 && i < rise_bits.size(); i++)
      chk($sformatf("f1_bit%0d", i), rise_bits[i], exp_seq[i]);
    for (int i = 0; i + 1 < rise_cyc.size(); i++)
      chk($sformatf("f1_rise_spacing%0d", i), rise_cyc[i+1] - rise_cyc[i], 4);
    chk("f1_busy_cycles", last_busy_run, 36);
    chk("f1_ack_cycles", ack_cnt - a0, 1);

    // Round robin with all four requesters held
    do_reset();
    req_data = 32'h44332211;
    @(posedge clk);
    grants.delete();
    a0 = ack_cnt;
    @(negedge clk);
    req = 4'b1111;
    wait_grants(5, 1000);
    @(negedge clk);
    req = 4'b0000;
    wait_idle("rr", 200);
    @(posedge clk);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk($sformatf("rr_grant%0d", i), grants[i], exp_rr[i]);
    chk("rr_ack_cycles", ack_cnt - a0, 5);

    // Pointer wrap after serving requester 2
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    wait_ack("wrap_pre", 50);
    chk("wrap_pre_grant", int'(grant_id), 2);
    req = 4'b0000;
    wait_idle("wrap_pre", 200);
    @(posedge clk);
    grants.delete();
    @(negedge clk);
    req = 4'b0101;
    wait_grants(2, 500);
    @(negedge clk);
    req = 4'b0000;
    wait_idle("wrap", 200);
    @(posedge clk);
    chk("wrap_grant0", (grants.size() > 0) ? grants[0] : -1, 0);
    chk("wrap_grant1", (grants.size() > 1) ? grants[1] : -1, 2);

    // Reset during bit 4, then a fresh grant
    do_reset();
    req_data = 32'h000000A5;
    a0 = ack_cnt;
    @(negedge clk);
    req = 4'b0001;
    wait_ack("abort", 50);
    req = 4'b0000;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sclk", int'(sclk), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_grant_id", int'(grant_id), 0);
    chk("abort_ack", int'(ack), 0);
    @(negedge clk);
    req = 4'b0010;
    wait_ack("post_abort", 50);
    chk("post_abort_ack", int'(ack), 2);
    chk("post_abort_grant_id", int'(grant_id), 1);
    req = 4'b0000;
    wait_idle("post_abort", 200);
    @(posedge clk);
    chk("abort_total_acks", ack_cnt - a0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
